uart_fifo_ctrl: RTL and testbench

- Sequences the simpleuart data-register port on behalf of a host so that firmware and other masters never poll for transmit or receive readiness.
- Holds a TX FIFO and drains it into the UART write port, honouring the UART's wait signal.
- Holds an RX FIFO and fills it by polling the UART read port, acknowledging each byte exactly once.
- Sits between the SoC bus-side UART register decoder and the simpleuart instance.

---
 rtl/uart_fifo_ctrl_pkg.sv | 22 ++
 rtl/uart_fifo_ctrl_if.sv | 30 +++
 rtl/uart_byte_fifo.sv | 55 +++++
 rtl/uart_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared encodings and constants for the UART FIFO controller.
// Imported by the controller top and its interface.
package uart_ctrl_pkg;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_WRITE = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_POLL = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;

  // simpleuart returns all ones when empty, otherwise a zero-extended byte
  function automatic logic byte_present(input logic [31:0] dat);
    return (dat[31:8] == 24'd0);
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Host-side port of the UART FIFO controller: TX push, RX pop, flushes and status.
interface uart_fifo_ctrl_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
);
  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int RX_LW = $clog2(RX_DEPTH) + 1;

  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             tx_flush;
  logic             rx_flush;
  logic [TX_LW-1:0] tx_level;
  logic [RX_LW-1:0] rx_level;
  logic             rx_stall;

  modport master (
    output tx_data, tx_valid, rx_ready, tx_flush, rx_flush,
    input  tx_ready, rx_data, rx_valid, tx_level, rx_level, rx_stall
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, tx_flush, rx_flush,
    output tx_ready, rx_data, rx_valid, tx_level, rx_level, rx_stall
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous 8-bit FIFO with a separate occupancy counter that reaches DEPTH.
// Flush wins over push and pop in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == {LW{1'b0}});
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign data_o    = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LW'(1'b1);
        2'b01:   level_q <= level_q - LW'(1'b1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffers host traffic to and from the simpleuart data register so that
// nobody polls for readiness: TX FIFO drains into reg_dat_we, RX FIFO fills from reg_dat_do.
module uart_fifo_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_fifo_ctrl_if.slave  host,
  output logic             uart_dat_we,
  output logic [7:0]       uart_dat_di,
  input  logic             uart_dat_wait,
  output logic             uart_dat_re,
  input  logic [31:0]      uart_dat_do
);
  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic       we_q, we_d;
  logic [7:0] di_q, di_d;
  logic       flush_pend_q, flush_pend_d;
  logic       re_q, re_d;
  logic       stall_q, stall_d;

  logic       tx_pop_s, tx_fifo_flush_s, tx_full_s, tx_empty_s;
  logic [7:0] tx_head_s;
  logic       rx_push_s, rx_full_s, rx_empty_s;

  uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (host.tx_valid && !host.tx_flush),
    .data_i  (host.tx_data),
    .pop_i   (tx_pop_s),
    .flush_i (tx_fifo_flush_s),
    .data_o  (tx_head_s),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s),
    .level_o (host.tx_level)
  );

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push_s),
    .data_i  (uart_dat_do[7:0]),
    .pop_i   (host.rx_ready),
    .flush_i (host.rx_flush),
    .data_o  (host.rx_data),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s),
    .level_o (host.rx_level)
  );

  assign host.tx_ready = !tx_full_s;
  assign host.rx_valid = !rx_empty_s;
  assign host.rx_stall = stall_q;
  assign uart_dat_we   = we_q;
  assign uart_dat_di   = di_q;
  assign uart_dat_re   = re_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      rx_state_q   <= RX_POLL;
      we_q         <= 1'b0;
      di_q         <= 8'd0;
      flush_pend_q <= 1'b0;
      re_q         <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      rx_state_q   <= rx_state_d;
      we_q         <= we_d;
      di_q         <= di_d;
      flush_pend_q <= flush_pend_d;
      re_q         <= re_d;
      stall_q      <= stall_d;
    end
  end

  // A flush seen while a byte is on the UART is held until that byte is accepted
  always_comb begin
    tx_state_d      = tx_state_q;
    we_d            = we_q;
    di_d            = di_q;
    flush_pend_d    = flush_pend_q;
    tx_pop_s        = 1'b0;
    tx_fifo_flush_s = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        we_d = 1'b0;
        if (host.tx_flush) begin
          tx_fifo_flush_s = 1'b1;
        end else if (!tx_empty_s) begin
          tx_state_d = TX_WRITE;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_WRITE: begin
        if (we_q && !uart_dat_wait) begin
          tx_pop_s        = 1'b1;
          tx_fifo_flush_s = host.tx_flush || flush_pend_q;
          flush_pend_d    = 1'b0;
          we_d            = 1'b0;
          tx_state_d      = TX_IDLE;
        end else begin
          we_d         = 1'b1;
          di_d         = tx_head_s;
          flush_pend_d = flush_pend_q || host.tx_flush;
        end
      end
      default: begin
        we_d       = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // RX_ACK ignores uart_dat_do: the byte is still visible until the read strobe lands
  always_comb begin
    rx_state_d = rx_state_q;
    re_d       = 1'b0;
    stall_d    = stall_q;
    rx_push_s  = 1'b0;
    case (rx_state_q)
      RX_POLL: begin
        if (byte_present(uart_dat_do) && !rx_full_s) begin
          rx_push_s  = 1'b1;
          re_d       = 1'b1;
          rx_state_d = RX_ACK;
        end else if (byte_present(uart_dat_do)) begin
          stall_d = 1'b1;
        end else begin
          stall_d = stall_q;
        end
      end
      RX_ACK: begin
        rx_state_d = RX_POLL;
      end
      default: begin
        rx_state_d = RX_POLL;
      end
    endcase
    if (host.rx_flush) begin
      stall_d = 1'b0;
    end else begin
      stall_d = stall_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed plus randomized bench for uart_fifo_ctrl with a queue-based host/UART model.
module tb_uart_fifo_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        uart_dat_we;
  logic [7:0]  uart_dat_di;
  logic        uart_dat_wait;
  logic        uart_dat_re;
  logic [31:0] uart_dat_do;

  uart_fifo_ctrl_if #(.TX_DEPTH(16), .RX_DEPTH(16)) bus ();

  uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .host          (bus),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .uart_dat_re   (uart_dat_re),
    .uart_dat_do   (uart_dat_do)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_pend [$];
  logic [7:0] tx_seen [$];
  logic [7:0] rx_exp  [$];
  logic [7:0] src     [$];
  int  re_cnt = 0;
  int  we_cnt = 0;
  int  we_hi_cnt = 0;
  int  re_consec = 0;
  bit  prev_re = 1'b0;
  bit  prev_hold = 1'b0;
  logic [7:0] prev_di = 8'd0;
  bit  tx_flush_defer = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_do();
    uart_dat_do = (src.size() > 0) ? {24'h0, src[0]} : 32'hFFFF_FFFF;
  endtask

  // One clock: sample at the edge, update the model, then check #1 later
  task automatic step();
    logic we_s, wt_s, re_s, rv_s;
    logic [7:0] di_s, rd_s;
    bit push_ok;
    @(posedge clk);
    we_s = uart_dat_we; wt_s = uart_dat_wait; di_s = uart_dat_di;
    re_s = uart_dat_re; rv_s = bus.rx_valid; rd_s = bus.rx_data;
    if (we_s) we_hi_cnt++;
    if (prev_hold) begin
      check("we_hold", {31'd0, we_s}, 32'd1);
      check("di_hold", {24'd0, di_s}, {24'd0, prev_di});
    end
    prev_hold = we_s && wt_s && !reset;
    prev_di = di_s;
    push_ok = bus.tx_valid && !bus.tx_flush && (tx_pend.size() < 16);
    if (reset) begin
      tx_pend.delete();
      rx_exp.delete();
      tx_flush_defer = 1'b0;
    end else begin
      if (we_s && !wt_s) begin
        tx_seen.push_back(di_s);
        we_cnt++;
        if (tx_pend.size() == 0) check("tx_accept_empty", 32'd1, 32'd0);
        else begin
          check("tx_byte", {24'd0, di_s}, {24'd0, tx_pend[0]});
          void'(tx_pend.pop_front());
        end
        if (tx_flush_defer) begin
          tx_pend.delete();
          tx_flush_defer = 1'b0;
        end
      end
      if (push_ok) tx_pend.push_back(bus.tx_data);
      if (re_s && src.size() > 0) rx_exp.push_back(src[0]);
      if (bus.rx_ready && rv_s) begin
        if (rx_exp.size() == 0) check("rx_pop_empty", 32'd1, 32'd0);
        else begin
          check("rx_byte", {24'd0, rd_s}, {24'd0, rx_exp[0]});
          void'(rx_exp.pop_front());
        end
      end
      if (bus.rx_flush) rx_exp.delete();
    end
    if (re_s) begin
      re_cnt++;
      if (prev_re) re_consec++;
      if (src.size() > 0) void'(src.pop_front());
    end
    prev_re = re_s;
    #1;
    drive_do();
    check("tx_level", 32'(bus.tx_level), 32'(tx_pend.size()));
    check("tx_ready", {31'd0, bus.tx_ready}, {31'd0, tx_pend.size() < 16});
    if (rx_exp.size() > 0) check("rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("rx_level_window",
          {31'd0, (32'(bus.rx_level) == 32'(rx_exp.size())) || (32'(bus.rx_level) == 32'(rx_exp.size()) + 32'd1)},
          32'd1);
  endtask

  initial begin
    int base_we, base_hi, base_re;
    logic [7:0] first_b;
    logic [7:0] b;
    reset = 1'b1;
    uart_dat_wait = 1'b0;
    uart_dat_do = 32'hFFFF_FFFF;
    bus.tx_data = 8'd0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    bus.tx_flush = 1'b0; bus.rx_flush = 1'b0;
    repeat (3) step();
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_tx_level", 32'(bus.tx_level), 32'd0);
    check("rst_rx_level", 32'(bus.rx_level), 32'd0);
    check("rst_stall", {31'd0, bus.rx_stall}, 32'd0);
    check("rst_we", {31'd0, uart_dat_we}, 32'd0);
    check("rst_re", {31'd0, uart_dat_re}, 32'd0);
    check("rst_di", {24'd0, uart_dat_di}, 32'd0);
    reset = 1'b0;
    step();

    // Three bytes drain in order, single-cycle strobes
    base_we = we_cnt; base_hi = we_hi_cnt;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h55; step();
    check("we_lat0", {31'd0, uart_dat_we}, 32'd0);
    bus.tx_data = 8'hA3; step();
    check("we_lat1", {31'd0, uart_dat_we}, 32'd0);
    bus.tx_data = 8'h00; step();
    bus.tx_valid = 1'b0;
    check("we_lat2", {31'd0, uart_dat_we}, 32'd1);
    check("di_first", {24'd0, uart_dat_di}, 32'h55);
    repeat (12) step();
    check("tx3_count", 32'(we_cnt - base_we), 32'd3);
    check("tx3_pulses", 32'(we_hi_cnt - base_hi), 32'd3);
    check("tx3_b2", {24'd0, tx_seen[tx_seen.size()-1]}, 32'h00);
    check("tx3_b1", {24'd0, tx_seen[tx_seen.size()-2]}, 32'hA3);

    // Long wait: strobe and data held, pop on first wait-low cycle
    uart_dat_wait = 1'b1;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h55; step();
    bus.tx_valid = 1'b0;
    step(); step();
    for (int i = 0; i < 40; i++) begin
      step();
      check("wait_we", {31'd0, uart_dat_we}, 32'd1);
      check("wait_di", {24'd0, uart_dat_di}, 32'h55);
    end
    uart_dat_wait = 1'b0;
    step();
    check("wait_pop_level", 32'(bus.tx_level), 32'd0);
    check("wait_pop_we", {31'd0, uart_dat_we}, 32'd0);
    check("wait_pop_byte", {24'd0, tx_seen[tx_seen.size()-1]}, 32'h55);

    // RX: 0xFF is a real byte; one read per byte
    base_re = re_cnt;
    src.push_back(8'hFF); src.push_back(8'h3C); drive_do();
    repeat (8) step();
    check("rx2_reads", 32'(re_cnt - base_re), 32'd2);
    check("rx2_consec", 32'(re_consec), 32'd0);
    check("rx2_level", 32'(bus.rx_level), 32'd2);
    check("rx2_head", {24'd0, bus.rx_data}, 32'hFF);
    bus.rx_ready = 1'b1; step(); step(); bus.rx_ready = 1'b0;
    step();
    check("rx2_drained", 32'(bus.rx_level), 32'd0);

    // RX full: stall, then accept after one pop, then flush
    for (int i = 0; i < 16; i++) src.push_back(8'($urandom));
    drive_do();
    base_re = re_cnt;
    repeat (40) step();
    check("rxf_level", 32'(bus.rx_level), 32'd16);
    check("rxf_reads", 32'(re_cnt - base_re), 32'd16);
    check("rxf_nostall", {31'd0, bus.rx_stall}, 32'd0);
    src.push_back(8'hAA); drive_do();
    base_re = re_cnt;
    repeat (6) step();
    check("rxf_noread", 32'(re_cnt - base_re), 32'd0);
    check("rxf_stall", {31'd0, bus.rx_stall}, 32'd1);
    bus.rx_ready = 1'b1; step(); bus.rx_ready = 1'b0;
    repeat (4) step();
    check("rxf_aa_read", 32'(re_cnt - base_re), 32'd1);
    check("rxf_refull", 32'(bus.rx_level), 32'd16);
    check("rxf_stall_sticky", {31'd0, bus.rx_stall}, 32'd1);
    bus.rx_flush = 1'b1; step(); bus.rx_flush = 1'b0;
    check("rxf_flush_level", 32'(bus.rx_level), 32'd0);
    check("rxf_flush_stall", {31'd0, bus.rx_stall}, 32'd0);
    check("rxf_flush_valid", {31'd0, bus.rx_valid}, 32'd0);

    // TX full, 17th byte dropped, deferred flush
    uart_dat_wait = 1'b1;
    bus.tx_valid = 1'b1;
    first_b = 8'($urandom);
    bus.tx_data = first_b; step();
    for (int i = 0; i < 16; i++) begin
      bus.tx_data = 8'($urandom); step();
    end
    bus.tx_valid = 1'b0;
    check("txf_level", 32'(bus.tx_level), 32'd16);
    check("txf_ready", {31'd0, bus.tx_ready}, 32'd0);
    bus.tx_flush = 1'b1; tx_flush_defer = 1'b1; step(); bus.tx_flush = 1'b0;
    step();
    check("txf_deferred", 32'(bus.tx_level), 32'd16);
    base_we = we_cnt;
    uart_dat_wait = 1'b0; step();
    check("txf_flushed", 32'(bus.tx_level), 32'd0);
    check("txf_head_sent", {24'd0, tx_seen[tx_seen.size()-1]}, {24'd0, first_b});
    repeat (6) step();
    check("txf_no_more", 32'(we_cnt - base_we), 32'd1);

    // Reset during a waiting write
    uart_dat_wait = 1'b1;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h11; step();
    bus.tx_data = 8'h22; step();
    bus.tx_valid = 1'b0; step(); step();
    check("rstw_we_before", {31'd0, uart_dat_we}, 32'd1);
    reset = 1'b1; step();
    check("rstw_we", {31'd0, uart_dat_we}, 32'd0);
    check("rstw_level", 32'(bus.tx_level), 32'd0);
    check("rstw_ready", {31'd0, bus.tx_ready}, 32'd1);
    reset = 1'b0; uart_dat_wait = 1'b0;
    base_we = we_cnt; base_hi = we_hi_cnt;
    repeat (10) step();
    check("rstw_no_write", 32'(we_hi_cnt - base_hi), 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 300; i++) begin
      bus.tx_valid = 1'($urandom_range(0, 1));
      bus.tx_data = 8'($urandom);
      uart_dat_wait = ($urandom_range(0, 9) < 3);
      bus.rx_ready = ($urandom_range(0, 3) != 0);
      if (src.size() < 2 && $urandom_range(0, 2) == 0) begin
        b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        src.push_back(b);
        drive_do();
      end
      step();
    end
    bus.tx_valid = 1'b0; uart_dat_wait = 1'b0; bus.rx_ready = 1'b1;
    repeat (80) step();
    check("rnd_tx_level", 32'(bus.tx_level), 32'd0);
    check("rnd_rx_level", 32'(bus.rx_level), 32'd0);
    check("rnd_src_left", 32'(src.size()), 32'd0);
    check("rnd_stall", {31'd0, bus.rx_stall}, 32'd0);
    check("rnd_re_consec", 32'(re_consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
